// File: rtl/mems_avalon_write_arbiter.sv
// rtl/mems_avalon_write_arbiter.sv - round-robin arbiter sharing one Avalon-MM write master
//
// Purpose: NUM_REQ writers each post one address/data pair with a level
// request. A round-robin arbiter with a per-requester enable mask grants one
// at a time, drives a single Avalon-MM write (held while waitrequest is high)
// and returns a one-cycle ack to the winner once the slave accepts.
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   req, req_enable          per-requester pending flag and arbitration mask
//   req_address, req_data    flattened per-requester address/data slices
//   ack                      one-cycle pulse to the requester whose write landed
//   grant_id                 index of the current or most recent grant
//   busy                     high while a transfer is in WRITE or DONE
//   write_count              total accepted writes, wraps at 2^32
//   address, write,
//   write_data, waitrequest  Avalon-MM write master
module mems_avalon_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_enable,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [2:0]                    grant_id,
  output logic                          busy,
  output logic [31:0]                   write_count,
  output logic [ADDR_WIDTH-1:0]         address,
  output logic                          write,
  output logic [DATA_WIDTH-1:0]         write_data,
  input  logic                          waitrequest
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             last_q, last_d;
  logic [2:0]             grant_id_q, grant_id_d;
  logic [ADDR_WIDTH-1:0]  address_q, address_d;
  logic [DATA_WIDTH-1:0]  write_data_q, write_data_d;
  logic                   write_q, write_d;
  logic                   busy_q, busy_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic [31:0]            write_count_q, write_count_d;

  // Round-robin scan results
  logic [NUM_REQ-1:0]     cand;
  logic                   found;
  logic [2:0]             winner;
  logic [ADDR_WIDTH-1:0]  win_address;
  logic [DATA_WIDTH-1:0]  win_data;

  // Offset k=1 is the requester right after the last one served, so the
  // last-served requester is only reached at k=NUM_REQ (lowest priority).
  always_comb begin
    cand        = req & req_enable;
    found       = 1'b0;
    winner      = 3'd0;
    win_address = '0;
    win_data    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && cand[i] && (((int'(last_q) + k) % NUM_REQ) == i)) begin
          found       = 1'b1;
          winner      = 3'(i);
          win_address = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
          win_data    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    grant_id_d    = grant_id_q;
    address_d     = address_q;
    write_data_d  = write_data_q;
    write_d       = write_q;
    busy_d        = busy_q;
    ack_d         = '0;
    write_count_d = write_count_q;

    case (state_q)
      ST_IDLE: begin
        write_d = 1'b0;
        busy_d  = 1'b0;
        if (found) begin
          // Requester slices are sampled only here; later changes are ignored.
          address_d    = win_address;
          write_data_d = win_data;
          grant_id_d   = winner;
          write_d      = 1'b1;
          busy_d       = 1'b1;
          state_d      = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // Avalon hold: outputs stay put until the slave drops waitrequest.
        if (!waitrequest) begin
          write_d = 1'b0;
          for (int i = 0; i < NUM_REQ; i++) begin
            ack_d[i] = (3'(i) == grant_id_q);
          end
          last_d        = grant_id_q;
          write_count_d = write_count_q + 32'd1;
          state_d       = ST_DONE;
        end
      end
      ST_DONE: begin
        // One dead cycle so the requester can retire or refresh its request.
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        write_d = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      last_q        <= 3'(NUM_REQ - 1);
      grant_id_q    <= 3'd0;
      address_q     <= '0;
      write_data_q  <= '0;
      write_q       <= 1'b0;
      busy_q        <= 1'b0;
      ack_q         <= '0;
      write_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      grant_id_q    <= grant_id_d;
      address_q     <= address_d;
      write_data_q  <= write_data_d;
      write_q       <= write_d;
      busy_q        <= busy_d;
      ack_q         <= ack_d;
      write_count_q <= write_count_d;
    end
  end

  assign ack         = ack_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;
  assign write_count = write_count_q;
  assign address     = address_q;
  assign write       = write_q;
  assign write_data  = write_data_q;

endmodule
